// File: rtl/cv32e41s_tcm_arbiter_if.sv
// Bus bundle between NUM_REQ OBI-style requesters, the arbiter and one TCM port.
// Handshake: a master's m_req_i is accepted in the cycle its m_gnt_o is high; exactly one
// cycle later the TCM answers with tcm_rvalid_i, which is returned to that master as m_rvalid_o.
interface cv32e41s_tcm_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int A_WID   = 32
);
  logic [NUM_REQ-1:0]       m_req_i;
  logic [NUM_REQ-1:0]       m_lock_i;
  logic [NUM_REQ-1:0]       m_we_i;
  logic [4*NUM_REQ-1:0]     m_be_i;
  logic [A_WID*NUM_REQ-1:0] m_addr_i;
  logic [32*NUM_REQ-1:0]    m_wdata_i;
  logic [NUM_REQ-1:0]       m_gnt_o;
  logic [NUM_REQ-1:0]       m_rvalid_o;
  logic [32*NUM_REQ-1:0]    m_rdata_o;
  logic                     tcm_req_o;
  logic                     tcm_we_o;
  logic [3:0]               tcm_be_o;
  logic [A_WID-1:0]         tcm_addr_o;
  logic [31:0]              tcm_wdata_o;
  logic                     tcm_rvalid_i;
  logic [31:0]              tcm_rdata_i;

  // Arbiter side.
  modport slave (
    input  m_req_i, m_lock_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, tcm_rvalid_i, tcm_rdata_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o, tcm_req_o, tcm_we_o, tcm_be_o, tcm_addr_o, tcm_wdata_o
  );

  // Requesters plus TCM side.
  modport master (
    output m_req_i, m_lock_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, tcm_rvalid_i, tcm_rdata_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o, tcm_req_o, tcm_we_o, tcm_be_o, tcm_addr_o, tcm_wdata_o
  );
endinterface

// File: rtl/cv32e41s_tcm_arbiter.sv
// Shares one TCM port among NUM_REQ requesters: same-cycle grant (round-robin or fixed
// priority) with optional per-master lock, and routing of the 1-cycle TCM response.
module cv32e41s_tcm_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int FIXED_PRIO = 0,
  parameter int A_WID      = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cv32e41s_tcm_arbiter_if.slave  bus,
  output logic                   err_o
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [IDW-1:0] pend_id_q, pend_id_d;
  logic           lock_valid_q, lock_valid_d;
  logic           pend_valid_q, pend_valid_d;
  logic           err_q, err_d;
  logic           rst_shadow_q, rst_shadow_d;

  logic [IDW-1:0] start;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] winner;
  logic           found;
  logic           grant;
  logic           lock_hold;

  always_comb begin
    lock_hold = lock_valid_q && bus.m_req_i[lock_id_q] && bus.m_lock_i[lock_id_q];
    start     = (FIXED_PRIO != 0) ? '0 : rr_ptr_q;
    grant     = |bus.m_req_i;
    winner    = '0;
    cand      = '0;
    found     = 1'b0;
    // First requester at or after the start index, wrapping around.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((int'(start) + i) % NUM_REQ);
      if (!found && bus.m_req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    if (lock_hold) begin
      winner = lock_id_q;
    end

    rr_ptr_d = rr_ptr_q;
    if (grant && !lock_hold) begin
      rr_ptr_d = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
    lock_valid_d = grant && bus.m_lock_i[winner];
    lock_id_d    = grant ? winner : lock_id_q;
    pend_valid_d = grant;
    pend_id_d    = grant ? winner : pend_id_q;

    // A response with nothing pending is tolerated only in the first cycle out of reset.
    err_d = err_q
          | (bus.tcm_rvalid_i & ~pend_valid_q & ~rst_shadow_q)
          | (pend_valid_q & ~bus.tcm_rvalid_i);
    rst_shadow_d = 1'b0;
  end

  always_comb begin
    bus.m_gnt_o     = '0;
    bus.tcm_req_o   = grant;
    bus.tcm_we_o    = 1'b0;
    bus.tcm_be_o    = '0;
    bus.tcm_addr_o  = '0;
    bus.tcm_wdata_o = '0;
    if (grant) begin
      bus.m_gnt_o     = NUM_REQ'(1) << winner;
      bus.tcm_we_o    = bus.m_we_i[winner];
      bus.tcm_be_o    = bus.m_be_i[4*winner +: 4];
      bus.tcm_addr_o  = bus.m_addr_i[A_WID*winner +: A_WID];
      bus.tcm_wdata_o = bus.m_wdata_i[32*winner +: 32];
    end
    // Responses arriving while reset is applied belong to a discarded transfer.
    bus.m_rvalid_o = '0;
    if (bus.tcm_rvalid_i && pend_valid_q && !rst_i) begin
      bus.m_rvalid_o = NUM_REQ'(1) << pend_id_q;
    end
    bus.m_rdata_o = {NUM_REQ{bus.tcm_rdata_i}};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_id_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_id_q    <= '0;
      err_q        <= 1'b0;
      rst_shadow_q <= 1'b1;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
      err_q        <= err_d;
      rst_shadow_q <= rst_shadow_d;
    end
  end

  assign err_o = err_q;
endmodule

// File: tb/tb_cv32e41s_tcm_arbiter.sv
// Bench for cv32e41s_tcm_arbiter: a round-robin and a fixed-priority instance share the
// same requester stimulus, each with its own 1-cycle TCM stub, checked against a reference model.
module tb_cv32e41s_tcm_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int W  = 41; // {id[7:0], we, rdata[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req, lock, we;
  logic [4*N-1:0]  be;
  logic [AW*N-1:0] addr;
  logic [32*N-1:0] wdata;
  logic            force_rv;
  logic            err_rr, err_fp;

  cv32e41s_tcm_arbiter_if #(.NUM_REQ(N), .A_WID(AW)) bus_rr ();
  cv32e41s_tcm_arbiter_if #(.NUM_REQ(N), .A_WID(AW)) bus_fp ();

  cv32e41s_tcm_arbiter #(.NUM_REQ(N), .FIXED_PRIO(0), .A_WID(AW)) dut_rr (
    .clk_i(clk), .rst_i(rst), .bus(bus_rr), .err_o(err_rr));
  cv32e41s_tcm_arbiter #(.NUM_REQ(N), .FIXED_PRIO(1), .A_WID(AW)) dut_fp (
    .clk_i(clk), .rst_i(rst), .bus(bus_fp), .err_o(err_fp));

  assign bus_rr.m_req_i   = req;   assign bus_fp.m_req_i   = req;
  assign bus_rr.m_lock_i  = lock;  assign bus_fp.m_lock_i  = lock;
  assign bus_rr.m_we_i    = we;    assign bus_fp.m_we_i    = we;
  assign bus_rr.m_be_i    = be;    assign bus_fp.m_be_i    = be;
  assign bus_rr.m_addr_i  = addr;  assign bus_fp.m_addr_i  = addr;
  assign bus_rr.m_wdata_i = wdata; assign bus_fp.m_wdata_i = wdata;

  // TCM stubs: answer every request one cycle later with a word derived from the address.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  logic        stub_rv_rr = 1'b0, stub_rv_fp = 1'b0;
  logic [31:0] stub_rd_rr = '0,   stub_rd_fp = '0;
  always @(posedge clk) begin
    stub_rv_rr <= bus_rr.tcm_req_o;
    stub_rd_rr <= mem_word(bus_rr.tcm_addr_o);
    stub_rv_fp <= bus_fp.tcm_req_o;
    stub_rd_fp <= mem_word(bus_fp.tcm_addr_o);
  end
  assign bus_rr.tcm_rvalid_i = stub_rv_rr | force_rv;
  assign bus_rr.tcm_rdata_i  = stub_rd_rr;
  assign bus_fp.tcm_rvalid_i = stub_rv_fp | force_rv;
  assign bus_fp.tcm_rdata_i  = stub_rd_fp;

  // ---------------- reference model / scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int rr_m[2]     = '{0, 0};
  int lock_m[2]   = '{-1, -1};
  bit err_m[2]    = '{1'b0, 1'b0};
  bit shadow_m[2] = '{1'b1, 1'b1};
  logic [W-1:0] exp_q_rr[$];
  logic [W-1:0] exp_q_fp[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lock owner keeps the port while it requests with lock; otherwise first requester from the start index.
  function automatic int model_winner(input logic [N-1:0] r, input logic [N-1:0] l,
                                      input int rr, input int lk, input bit fixed);
    int s;
    if (r == '0) return -1;
    if (lk >= 0 && r[lk] && l[lk]) return lk;
    s = fixed ? 0 : rr;
    for (int k = 0; k < N; k++) begin
      if (r[(s + k) % N]) return (s + k) % N;
    end
    return -1;
  endfunction

  task automatic check_inst(input int inst, input logic [N-1:0] gnt, input logic [N-1:0] rv,
                            input logic treq, input logic twe, input logic [3:0] tbe,
                            input logic [AW-1:0] taddr, input logic [31:0] twd,
                            input logic [32*N-1:0] rdat, input logic rv_in, input logic err);
    string        p;
    bit           fixed, hold, have;
    int           w, id;
    logic [W-1:0] e;
    logic [63:0]  exp_gnt, exp_rv;
    logic         exp_we;
    logic [3:0]   exp_be;
    logic [AW-1:0] exp_addr;
    logic [31:0]  exp_wd;
    p     = (inst == 0) ? "rr" : "fp";
    fixed = (inst == 1);
    hold  = (lock_m[inst] >= 0) && req[lock_m[inst]] && lock[lock_m[inst]];
    w     = model_winner(req, lock, rr_m[inst], lock_m[inst], fixed);

    exp_gnt = '0; exp_we = 1'b0; exp_be = '0; exp_addr = '0; exp_wd = '0;
    if (w >= 0) begin
      exp_gnt  = 64'(1) << w;
      exp_we   = we[w];
      exp_be   = be[4*w +: 4];
      exp_addr = addr[AW*w +: AW];
      exp_wd   = wdata[32*w +: 32];
    end
    chk({p, "_err"},   err,   err_m[inst]);
    chk({p, "_gnt"},   gnt,   exp_gnt);
    chk({p, "_treq"},  treq,  w >= 0);
    chk({p, "_twe"},   twe,   exp_we);
    chk({p, "_tbe"},   tbe,   exp_be);
    chk({p, "_taddr"}, taddr, exp_addr);
    chk({p, "_twd"},   twd,   exp_wd);

    have = 1'b0;
    e    = '0;
    if (inst == 0 && exp_q_rr.size() > 0) begin e = exp_q_rr.pop_front(); have = 1'b1; end
    if (inst == 1 && exp_q_fp.size() > 0) begin e = exp_q_fp.pop_front(); have = 1'b1; end
    id     = int'(e[40:33]);
    exp_rv = (have && !rst) ? (64'(1) << id) : 64'(0);
    chk({p, "_rvalid"}, rv, exp_rv);
    if (have && !rst && !e[32]) chk({p, "_rdata"}, rdat[32*id +: 32], e[31:0]);

    if (rst) begin
      rr_m[inst] = 0; lock_m[inst] = -1; err_m[inst] = 1'b0; shadow_m[inst] = 1'b1;
      if (inst == 0) exp_q_rr.delete(); else exp_q_fp.delete();
    end else begin
      if ((rv_in && !have && !shadow_m[inst]) || (have && !rv_in)) err_m[inst] = 1'b1;
      shadow_m[inst] = 1'b0;
      if (w >= 0) begin
        if (!hold) rr_m[inst] = (w + 1) % N;
        lock_m[inst] = lock[w] ? w : -1;
        e = {8'(w), we[w], we[w] ? 32'h0 : mem_word(addr[AW*w +: AW])};
        if (inst == 0) exp_q_rr.push_back(e); else exp_q_fp.push_back(e);
      end else begin
        lock_m[inst] = -1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_all();
    req = '0; lock = '0; we = '0; be = '0; addr = '0; wdata = '0; force_rv = 1'b0;
  endtask

  task automatic drive(input int k, input logic r, input logic l, input logic w_en,
                       input logic [3:0] b, input logic [AW-1:0] a, input logic [31:0] d);
    req[k] = r; lock[k] = l; we[k] = w_en;
    be[4*k +: 4] = b; addr[AW*k +: AW] = a; wdata[32*k +: 32] = d;
  endtask

  task automatic cycle();
    #2;
    check_inst(0, bus_rr.m_gnt_o, bus_rr.m_rvalid_o, bus_rr.tcm_req_o, bus_rr.tcm_we_o,
               bus_rr.tcm_be_o, bus_rr.tcm_addr_o, bus_rr.tcm_wdata_o, bus_rr.m_rdata_o,
               bus_rr.tcm_rvalid_i, err_rr);
    check_inst(1, bus_fp.m_gnt_o, bus_fp.m_rvalid_o, bus_fp.tcm_req_o, bus_fp.tcm_we_o,
               bus_fp.tcm_be_o, bus_fp.tcm_addr_o, bus_fp.tcm_wdata_o, bus_fp.m_rdata_o,
               bus_fp.tcm_rvalid_i, err_fp);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    clear_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then single master read at 0x10.
    cycle();
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h10, 32'h0);
    cycle();
    clear_all();
    cycle();

    // Contention between masters 0 and 1 for four cycles.
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 32'h200, 32'h0);
    repeat (4) cycle();
    clear_all();
    cycle();

    // Master 1 takes the lock alone, holds it against master 0, then releases.
    drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
    cycle();
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h400, 32'h0);
    repeat (3) cycle();
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    clear_all();
    cycle();

    // Partial write from master 1.
    drive(1, 1'b1, 1'b0, 1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF);
    cycle();
    clear_all();
    cycle();

    // Random traffic including locks and master 2.
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < N; k++) begin
        drive(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
      end
      cycle();
    end
    clear_all();
    cycle();

    // Reset one cycle after a grant; a request issued during reset leaves a stale response.
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h44, 32'h0);
    cycle();
    clear_all();
    drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 32'h48, 32'h0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_all();
    repeat (2) cycle();

    // Spurious response with nothing pending sets the sticky error.
    force_rv = 1'b1;
    cycle();
    force_rv = 1'b0;
    drive(2, 1'b1, 1'b0, 1'b0, 4'hF, 32'h50, 32'h0);
    cycle();
    clear_all();
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cv32e41s_tcm_arbiter.md
Name: cv32e41s_tcm_arbiter

Overview:
- Shares one TCM port among NUM_REQ OBI-style requesters (e.g. core data LSU, debug/loader, DMA).
- Sits directly in front of one TCM port; the TCM's other port stays private to instruction fetch.
- Performs same-cycle grant with round-robin or fixed priority and an optional per-master lock, then routes the 1-cycle-latency TCM response back to the granted master.
- Sustains one transfer per cycle.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority with lowest index highest.
- A_WID, 32, address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- m_req_i  in  NUM_REQ  per-master request.
- m_lock_i  in  NUM_REQ  master holds arbitration while asserted.
- m_we_i  in  NUM_REQ  write enable.
- m_be_i  in  4*NUM_REQ  byte enables; master k uses bits [4k+:4].
- m_addr_i  in  A_WID*NUM_REQ  address.
- m_wdata_i  in  32*NUM_REQ  write data.
- m_gnt_o  out  NUM_REQ  grant, one-hot or zero.
- m_rvalid_o  out  NUM_REQ  response valid.
- m_rdata_o  out  32*NUM_REQ  read data; all slices carry tcm_rdata_i.
- tcm_req_o  out  1  request to TCM.
- tcm_we_o  out  1  write enable to TCM.
- tcm_be_o  out  4  byte enables to TCM.
- tcm_addr_o  out  A_WID  address to TCM.
- tcm_wdata_o  out  32  write data to TCM.
- tcm_rvalid_i  in  1  TCM response valid; always 1 cycle after tcm_req_o.
- tcm_rdata_i  in  32  TCM read data.
- err_o  out  1  sticky protocol error.

Behaviour:
- Clock and reset:
  - Single clock clk_i.
  - rst_i is synchronous, active-high. At reset: rr_ptr=0, lock_owner invalid, pend_valid=0, pend_id=0, err_o=0, rst_shadow=1.
- Grant (combinational):
  - If lock_owner is valid and that master's m_req_i=1, it wins.
  - Otherwise the winner is the first requesting master scanning from rr_ptr upward with wrap-around. With FIXED_PRIO=1 the scan starts from 0.
  - m_gnt_o[winner]=1 in the same cycle as its request.
  - tcm_req_o equals the OR of m_req_i.
  - tcm_we_o, tcm_be_o, tcm_addr_o and tcm_wdata_o are muxed from the winner; they are 0 when idle.
  - With no request, all outputs to the TCM are 0.
- Round-robin pointer:
  - On each grant, rr_ptr <= winner+1 modulo NUM_REQ.
  - While a lock is held, rr_ptr is unchanged.
- Lock:
  - A granted master with m_lock_i=1 becomes lock_owner.
  - The lock is released on the first cycle in which the owner's m_lock_i=0, or the owner's m_req_i=0.
  - On release, arbitration resumes in that same cycle.
- Response routing:
  - On a grant: pend_valid<=1 and pend_id<=winner. Otherwise pend_valid<=0.
  - When tcm_rvalid_i=1 and pend_valid=1, m_rvalid_o[pend_id]=1 and all other bits are 0.
  - Latency request-to-rvalid is 1 cycle. Back-to-back grants to different masters return responses in order, one per cycle.
  - Writes also receive rvalid; rdata is don't-care for writes.
- Error detection:
  - err_o is set if tcm_rvalid_i=1 while pend_valid=0 and rst_shadow=0, or if pend_valid=1 and tcm_rvalid_i=0.
  - err_o is cleared only by reset.
  - rst_shadow drops to 0 one cycle after reset deasserts, so a stale rvalid left in flight from before reset is dropped silently.
- Reset mid-transfer: the in-flight response is discarded and no m_rvalid_o is asserted.
- Simultaneous events: a new grant and the routing of the previous response happen in the same cycle.

Test Plan:
- Single master: m_req_i=2'b01, addr=0x10, we=0 -> m_gnt_o=01 in cycle 0; tcm_addr_o=0x10; m_rvalid_o=01 in cycle 1 with rdata equal to the TCM word.
- Contention with round-robin: m_req_i=2'b11 held for 4 cycles -> grants 01,10,01,10; responses routed to masters 0,1,0,1 one cycle later.
- FIXED_PRIO=1, m_req_i=2'b11 for 3 cycles -> m_gnt_o=01 every cycle; master 1 is starved.
- Lock: master 1 asserts req+lock for 3 cycles while master 0 requests -> gnt=10 ×3; master 0 is granted the cycle lock drops.
- Write path: master 1 writes be=4'b0011, wdata=0xDEADBEEF at 0x20 -> tcm_we_o=1, tcm_be_o=0011; rvalid to master 1 one cycle later.
- Reset mid-transfer: assert rst_i in the cycle after a grant while tcm_rvalid_i=1 -> no m_rvalid_o, err_o stays 0. A spurious tcm_rvalid_i later with no pending transfer -> err_o=1 sticky.
